// File: rtl/dbus_axi_master.sv
// -----------------------------------------------------------------------------
// dbus_axi_master
// AXI4-Lite initiator for the CPU MEM-stage data port. Each load or store
// becomes exactly one AXI4-Lite transaction. The pipeline is held through
// cpu_stall until the response returns.
// Load size/sign travel on ARPROT = {size, sign_ext}. Store size and alignment
// travel on WSTRB.
//
// Optional feature: define DBUS_TIMEOUT_EN to abort a transaction that stays
// busy for TIMEOUT_CYCLES. The abort completes with cpu_err=1 and cpu_rdata=0.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   cpu_memread / cpu_memwrite     load / store request, held while stalled
//   cpu_addr, cpu_wdata            byte address, unshifted store data
//   cpu_byte_size, cpu_sign_ext    00 byte, 01 half, 10/11 word; load sign
//   cpu_rdata, cpu_done, cpu_err   registered completion (1-cycle pulse)
//   cpu_stall                      combinational pipeline hold
//   M_AXI_*                        AXI4-Lite master (AW, W, B, AR, R)
// -----------------------------------------------------------------------------
module dbus_axi_master #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_memread,
    input  logic        cpu_memwrite,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_byte_size,
    input  logic        cpu_sign_ext,
    output logic [31:0] cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic        cpu_stall,
    output logic [31:0] M_AXI_AWADDR,
    output logic [2:0]  M_AXI_AWPROT,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    output logic [31:0] M_AXI_ARADDR,
    output logic [2:0]  M_AXI_ARPROT,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_REQ,
        S_W_RESP,
        S_R_REQ,
        S_R_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic        awvalid_q, awvalid_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic [31:0] araddr_q, araddr_d;
    logic [2:0]  arprot_q, arprot_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

`ifdef DBUS_TIMEOUT_EN
    localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

    // Byte lanes for a store; addr[0] is ignored for halves, size 11 acts as word.
    function automatic logic [3:0] strb_for(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] s;
        case (size)
            2'b00:   s = 4'b0001 << a;
            2'b01:   s = a[1] ? 4'b1100 : 4'b0011;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            awaddr_q  <= '0;
            awvalid_q <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            araddr_q  <= '0;
            arprot_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef DBUS_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            awaddr_q  <= awaddr_d;
            awvalid_q <= awvalid_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            araddr_q  <= araddr_d;
            arprot_q  <= arprot_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef DBUS_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        awaddr_d  = awaddr_q;
        awvalid_d = awvalid_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        araddr_d  = araddr_q;
        arprot_d  = arprot_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        rdata_d   = rdata_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
`ifdef DBUS_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                // done_q masks a request still held during the completion cycle.
                if ((cpu_memwrite || cpu_memread) && !done_q) begin
                    if (cpu_memwrite) begin
                        state_d   = S_W_REQ;
                        awaddr_d  = cpu_addr;
                        wdata_d   = cpu_wdata;
                        wstrb_d   = strb_for(cpu_byte_size, cpu_addr[1:0]);
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_R_REQ;
                        araddr_d  = cpu_addr;
                        arprot_d  = {cpu_byte_size, cpu_sign_ext};
                        arvalid_d = 1'b1;
                    end
`ifdef DBUS_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end

            S_W_REQ: begin
                // AW and W complete independently; move on once both VALIDs are down.
                if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
                if (!awvalid_q && !wvalid_q) begin
                    state_d  = S_W_RESP;
                    bready_d = 1'b1;
                end
            end

            S_W_RESP: begin
                if (M_AXI_BVALID && bready_q) begin
                    bready_d = 1'b0;
                    done_d   = 1'b1;
                    err_d    = (M_AXI_BRESP != 2'b00);
                    state_d  = S_IDLE;
                end
            end

            S_R_REQ: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_R_RESP;
                end
            end

            S_R_RESP: begin
                if (M_AXI_RVALID && rready_q) begin
                    rdata_d  = M_AXI_RDATA;
                    rready_d = 1'b0;
                    done_d   = 1'b1;
                    err_d    = (M_AXI_RRESP != 2'b00);
                    state_d  = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

`ifdef DBUS_TIMEOUT_EN
        // Abort on the busy cycle where the counter reaches TIMEOUT_CYCLES-1
        // without a response; a late B/R is ignored because READY is dropped.
        if (state_q != S_IDLE && !done_d) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CNT_LAST) begin
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                rdata_d   = '0;
                done_d    = 1'b1;
                err_d     = 1'b1;
                state_d   = S_IDLE;
            end
        end
`endif
    end

    assign cpu_stall     = (cpu_memread || cpu_memwrite) && !done_q;
    assign cpu_rdata     = rdata_q;
    assign cpu_done      = done_q;
    assign cpu_err       = err_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARPROT  = arprot_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_dbus_axi_master.sv
// -----------------------------------------------------------------------------
// tb_dbus_axi_master
// Directed bench for dbus_axi_master with a small configurable AXI4-Lite slave.
// Inputs are driven and outputs sampled on the falling edge. The latency "lat"
// counts rising edges from the request being driven until cpu_done is seen.
// -----------------------------------------------------------------------------
module tb_dbus_axi_master;

`ifdef DBUS_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT_CYCLES = 16;
`else
    localparam int unsigned TB_TIMEOUT_CYCLES = 256;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_memread, cpu_memwrite;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [1:0]  cpu_byte_size;
    logic        cpu_sign_ext;
    logic [31:0] cpu_rdata;
    logic        cpu_done, cpu_err, cpu_stall;
    logic [31:0] M_AXI_AWADDR;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_AWVALID, M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY;
    logic [31:0] M_AXI_ARADDR;
    logic [2:0]  M_AXI_ARPROT;
    logic        M_AXI_ARVALID, M_AXI_ARREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    always #5 clk = ~clk;

    dbus_axi_master #(.TIMEOUT_CYCLES(TB_TIMEOUT_CYCLES)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_byte_size(cpu_byte_size), .cpu_sign_ext(cpu_sign_ext),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_stall(cpu_stall),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    // ---------------- slave model ----------------
    int          aw_lat, w_lat, ar_lat, r_lat;   // extra cycles before READY / RVALID
    logic        ar_never, b_hold;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp, s_bresp;
    int          aw_cnt, w_cnt, ar_cnt, r_wait;
    logic        aw_seen, w_seen, r_pend;

    assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_lat);
    assign M_AXI_WREADY  = M_AXI_WVALID && (w_cnt >= w_lat);
    assign M_AXI_ARREADY = M_AXI_ARVALID && !ar_never && (ar_cnt >= ar_lat);
    assign M_AXI_RDATA   = s_rdata;
    assign M_AXI_RRESP   = s_rresp;
    assign M_AXI_BRESP   = s_bresp;

    always @(posedge clk) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_wait <= 0;
            aw_seen <= 1'b0; w_seen <= 1'b0; r_pend <= 1'b0;
            M_AXI_BVALID <= 1'b0; M_AXI_RVALID <= 1'b0;
        end else begin
            aw_cnt <= (M_AXI_AWVALID && !M_AXI_AWREADY) ? aw_cnt + 1 : 0;
            w_cnt  <= (M_AXI_WVALID && !M_AXI_WREADY) ? w_cnt + 1 : 0;
            ar_cnt <= (M_AXI_ARVALID && !M_AXI_ARREADY) ? ar_cnt + 1 : 0;
            if (M_AXI_BVALID && M_AXI_BREADY) begin
                M_AXI_BVALID <= 1'b0; aw_seen <= 1'b0; w_seen <= 1'b0;
            end else begin
                if (M_AXI_AWVALID && M_AXI_AWREADY) aw_seen <= 1'b1;
                if (M_AXI_WVALID && M_AXI_WREADY)   w_seen  <= 1'b1;
                if (!M_AXI_BVALID && !b_hold
                    && (aw_seen || (M_AXI_AWVALID && M_AXI_AWREADY))
                    && (w_seen || (M_AXI_WVALID && M_AXI_WREADY)))
                    M_AXI_BVALID <= 1'b1;
            end
            if (M_AXI_RVALID && M_AXI_RREADY) begin
                M_AXI_RVALID <= 1'b0; r_pend <= 1'b0;
            end else if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                r_pend <= 1'b1; r_wait <= r_lat; M_AXI_RVALID <= (r_lat == 0);
            end else if (r_pend && !M_AXI_RVALID) begin
                if (r_wait <= 1) M_AXI_RVALID <= 1'b1;
                r_wait <= r_wait - 1;
            end
        end
    end

    // Handshake / completion counters
    int n_aw = 0, n_ar = 0, n_b = 0, n_done = 0;
    always @(posedge clk) begin
        if (M_AXI_AWVALID && M_AXI_AWREADY) n_aw <= n_aw + 1;
        if (M_AXI_ARVALID && M_AXI_ARREADY) n_ar <= n_ar + 1;
        if (M_AXI_BVALID && M_AXI_BREADY)   n_b  <= n_b + 1;
        if (cpu_done)                       n_done <= n_done + 1;
    end

    // ---------------- checking ----------------
    int n_checks = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Results of the last do_op
    int          lat;
    logic        op_err, stall_bad, stall_at_done, done_after;
    logic [31:0] op_rdata, cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;
    logic [2:0]  cap_awprot, cap_arprot;
    logic        cap_arvalid_at_done;
    logic [15:0] aw_tr, w_tr;

    // Called at a falling edge; returns at a falling edge with the request dropped.
    task automatic do_op(input logic wr, input logic rd, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [1:0] sz, input logic sx,
                         input bit hold, input int budget);
        bit got_done;
        cpu_memwrite = wr; cpu_memread = rd; cpu_addr = addr;
        cpu_wdata = wd; cpu_byte_size = sz; cpu_sign_ext = sx;
        lat = 0; stall_bad = 1'b0; aw_tr = '0; w_tr = '0; got_done = 1'b0;
        for (int i = 0; i < budget && !got_done; i++) begin
            @(negedge clk);
            lat++;
            if (lat <= 16) begin
                aw_tr[lat-1] = M_AXI_AWVALID;
                w_tr[lat-1]  = M_AXI_WVALID;
            end
            if (M_AXI_AWVALID) begin
                cap_awaddr = M_AXI_AWADDR; cap_awprot = M_AXI_AWPROT;
                cap_wdata = M_AXI_WDATA; cap_wstrb = M_AXI_WSTRB;
            end
            if (M_AXI_ARVALID) begin
                cap_araddr = M_AXI_ARADDR; cap_arprot = M_AXI_ARPROT;
            end
            if (cpu_done) begin
                got_done = 1'b1; op_err = cpu_err; op_rdata = cpu_rdata;
                stall_at_done = cpu_stall; cap_arvalid_at_done = M_AXI_ARVALID;
            end else if (!cpu_stall) begin
                stall_bad = 1'b1;
            end
        end
        if (!got_done) check("op_done_within_budget", 32'(lat), 32'(budget + 1));
        if (!hold) begin cpu_memwrite = 1'b0; cpu_memread = 1'b0; end
        @(negedge clk);
        done_after = cpu_done;
        cpu_memwrite = 1'b0; cpu_memread = 1'b0;
    endtask

    logic [31:0] st_addr [6] = '{32'h203, 32'h202, 32'h200, 32'h201, 32'h201, 32'h202};
    logic [1:0]  st_size [6] = '{2'b00,   2'b01,   2'b10,   2'b00,   2'b01,   2'b11};
    logic [3:0]  st_strb [6] = '{4'b1000, 4'b1100, 4'b1111, 4'b0010, 4'b0011, 4'b1111};

    initial begin
        int base_aw, base_ar, base_b, base_done;
        bit  seen;
        rst = 1'b1;
        cpu_memread = 1'b0; cpu_memwrite = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        cpu_byte_size = 2'b00; cpu_sign_ext = 1'b0;
        aw_lat = 0; w_lat = 0; ar_lat = 0; r_lat = 0;
        ar_never = 1'b0; b_hold = 1'b0;
        s_rdata = 32'hDEADBEEF; s_rresp = 2'b00; s_bresp = 2'b00;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_valid_ready", {27'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                                  M_AXI_ARVALID, M_AXI_RREADY}, 32'd0);
        check("rst_done_err", {30'd0, cpu_done, cpu_err}, 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_addr_data", M_AXI_AWADDR | M_AXI_ARADDR | M_AXI_WDATA, 32'd0);
        check("rst_prot_strb", {25'd0, M_AXI_AWPROT, M_AXI_ARPROT, 1'b0} | {28'd0, M_AXI_WSTRB}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: zero-wait load word, sign-extend -> ARPROT 101
        do_op(1'b0, 1'b1, 32'h100, 32'h0, 2'b10, 1'b1, 1'b0, 32);
        check("t1_lat", 32'(lat), 32'd3);
        check("t1_araddr", cap_araddr, 32'h100);
        check("t1_arprot", 32'(cap_arprot), 32'd5);
        check("t1_rdata", op_rdata, 32'hDEADBEEF);
        check("t1_err", 32'(op_err), 32'd0);
        check("t1_stall_at_done", 32'(stall_at_done), 32'd0);
        check("t1_stall_while_busy", 32'(stall_bad), 32'd0);
        check("t1_done_one_cycle", 32'(done_after), 32'd0);

        // 2: store strobes by size and address
        for (int i = 0; i < 6; i++) begin
            do_op(1'b1, 1'b0, st_addr[i], 32'hAB, st_size[i], 1'b0, 1'b0, 32);
            check($sformatf("t2_wstrb_%0d", i), 32'(cap_wstrb), 32'(st_strb[i]));
            if (i == 0) begin
                check("t2_lat", 32'(lat), 32'd4);
                check("t2_awaddr", cap_awaddr, 32'h203);
                check("t2_wdata", cap_wdata, 32'hAB);
                check("t2_awprot", 32'(cap_awprot), 32'd0);
            end
        end
        check("t2_rdata_kept", cpu_rdata, 32'hDEADBEEF);

        // 3: WREADY two cycles after AWREADY
        w_lat = 2;
        base_b = n_b; base_done = n_done;
        do_op(1'b1, 1'b0, 32'h300, 32'h1234, 2'b10, 1'b0, 1'b0, 32);
        repeat (3) @(negedge clk);
        check("t3_awvalid_trace", 32'(aw_tr[3:0]), 32'h1);
        check("t3_wvalid_trace", 32'(w_tr[3:0]), 32'h7);
        check("t3_lat", 32'(lat), 32'd6);
        check("t3_one_b", 32'(n_b - base_b), 32'd1);
        check("t3_one_done", 32'(n_done - base_done), 32'd1);
        w_lat = 0;

        // 4: RVALID delayed 5 cycles, RRESP=SLVERR
        r_lat = 5; s_rresp = 2'b10; s_rdata = 32'h12345678;
        do_op(1'b0, 1'b1, 32'h140, 32'h0, 2'b01, 1'b0, 1'b0, 32);
        check("t4_lat", 32'(lat), 32'd8);
        check("t4_stall_held", 32'(stall_bad), 32'd0);
        check("t4_err", 32'(op_err), 32'd1);
        check("t4_rdata", op_rdata, 32'h12345678);
        check("t4_arprot_half", 32'(cap_arprot), 32'd2);
        r_lat = 0; s_rresp = 2'b00;

        // 4b: read and write together -> only AW/W
        base_aw = n_aw; base_ar = n_ar;
        do_op(1'b1, 1'b1, 32'h180, 32'h55, 2'b10, 1'b0, 1'b0, 32);
        check("t4b_no_ar", 32'(n_ar - base_ar), 32'd0);
        check("t4b_one_aw", 32'(n_aw - base_aw), 32'd1);
        check("t4b_err", 32'(op_err), 32'd0);

        // 5: request held through the completion cycle
        base_ar = n_ar; base_done = n_done;
        do_op(1'b0, 1'b1, 32'h1C0, 32'h0, 2'b10, 1'b0, 1'b1, 32);
        repeat (3) @(negedge clk);
        check("t5_one_ar", 32'(n_ar - base_ar), 32'd1);
        check("t5_one_done", 32'(n_done - base_done), 32'd1);
        check("t5_arvalid_idle", 32'(M_AXI_ARVALID), 32'd0);

        // 5b: reset while waiting in W_RESP
        b_hold = 1'b1;
        cpu_memwrite = 1'b1; cpu_addr = 32'h400; cpu_wdata = 32'h99; cpu_byte_size = 2'b10;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (M_AXI_BREADY) seen = 1'b1;
        end
        check("t5b_reached_wresp", 32'(seen), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t5b_valid_ready_cleared", {27'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                                          M_AXI_ARVALID, M_AXI_RREADY}, 32'd0);
        @(negedge clk);
        rst = 1'b0; cpu_memwrite = 1'b0; b_hold = 1'b0;
        base_done = n_done;
        repeat (4) @(negedge clk);
        check("t5b_no_done", 32'(n_done - base_done), 32'd0);

`ifdef DBUS_TIMEOUT_EN
        // 6: ARREADY never arrives, TIMEOUT_CYCLES=16
        ar_never = 1'b1;
        do_op(1'b0, 1'b1, 32'h500, 32'h0, 2'b10, 1'b0, 1'b0, 64);
        check("t6_lat", 32'(lat), 32'd16);
        check("t6_err", 32'(op_err), 32'd1);
        check("t6_rdata", op_rdata, 32'd0);
        check("t6_arvalid", 32'(cap_arvalid_at_done), 32'd0);
        ar_never = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
